control_unit_mc: RTL and testbench

Parametrised ID-stage control unit for the ARM pipeline. Decodes mode/op_code/S into memory, write-back, branch and ALU-command controls, and sequences multi-cycle execute operations (EXP, optionally MUL) with configurable latency. While a multi-cycle operation runs, it stalls the pipeline through an explicit handshake.

---
 rtl/cu_pkg.sv | 58 +++++
 rtl/cu_mc_timer.sv | 91 +++++++++
 rtl/control_unit_mc.sv | 83 ++++++++
 tb/tb_control_unit_mc.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared constants, state type and opcode-to-ALU-command mapping for control_unit_mc.
// Optional MUL support is enabled by defining MUL_EN.
package cu_pkg;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_EXP = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0111;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } cu_state_t;

    // CMP and TST reuse the SUB and AND datapaths with write-back suppressed.
    function automatic logic [3:0] exe_cmd_of(input logic [3:0] op);
        case (op)
            OP_MOV:  return EXE_MOV;
            OP_MVN:  return EXE_MVN;
            OP_ADD:  return EXE_ADD;
            OP_ADC:  return EXE_ADC;
            OP_SUB:  return EXE_SUB;
            OP_SBC:  return EXE_SBC;
            OP_AND:  return EXE_AND;
            OP_ORR:  return EXE_ORR;
            OP_EOR:  return EXE_EOR;
            OP_CMP:  return EXE_SUB;
            OP_TST:  return EXE_AND;
            default: return EXE_NOP;
        endcase
    endfunction

endpackage

// File: rtl/cu_mc_timer.sv
// Multi-cycle operation sequencer: IDLE/BUSY/DONE FSM, latency counter and unit-select latch.
// Latency is EXP_LAT when the latched select is 0, MUL_LAT when it is 1 (MUL_EN builds only).
module cu_mc_timer
    import cu_pkg::*;
#(
    parameter int EXP_LAT = 20,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_sel,
    input  logic i_flush,
    output logic o_busy,
    output logic o_done,
    output logic o_stall_hold,
    output logic o_sel
);

    if (EXP_LAT < 2 || MUL_LAT < 2 ||
        (1 << CNT_W) <= EXP_LAT || (1 << CNT_W) <= MUL_LAT) begin : g_param_err
        $error("cu_mc_timer: latencies must be >= 2 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] EXP_LAST = CNT_W'(EXP_LAT - 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

    cu_state_t        r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt, w_next_cnt;
    logic             r_sel, w_next_sel;
    logic [CNT_W-1:0] w_last;

    assign w_last = r_sel ? MUL_LAST : EXP_LAST;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_sel   <= w_next_sel;
        end
    end

    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_sel   = r_sel;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next_state = BUSY;
                    w_next_cnt   = CNT_W'(1);
                    w_next_sel   = i_sel;
                end
            end
            BUSY: begin
                if (i_flush) begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else if (r_cnt == w_last) begin
                    w_next_state = DONE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt   = r_cnt + 1'b1;
                end
            end
            DONE: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_comb begin
        o_busy       = (r_state != IDLE);
        o_done       = (r_state == DONE);
        o_stall_hold = (r_state == BUSY);
        o_sel        = r_sel;
    end

endmodule

// File: rtl/control_unit_mc.sv
// ID-stage control unit: combinational decode plus stall handshake for multi-cycle EXP/MUL ops.
// Define MUL_EN to treat mode 00 / opcode 0111 as a multi-cycle MUL of MUL_LAT cycles.
module control_unit_mc
    import cu_pkg::*;
#(
    parameter int EXP_LAT = 20,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic       flush,
    input  logic       s,
    input  logic [1:0] mode,
    input  logic [3:0] op_code,
    output logic       mem_r_en,
    output logic       mem_w_en,
    output logic       b,
    output logic       s_out,
    output logic       wb_en,
    output logic [3:0] exe_cmd,
    output logic       mc_start,
    output logic       mc_sel,
    output logic       stall,
    output logic       busy
);

    logic w_is_dp, w_is_mem, w_is_br, w_is_cmp_tst;
    logic w_mc_op, w_mul_sel, w_start;
    logic w_busy, w_done, w_stall_hold;

    assign w_is_dp      = (mode == MODE_DP);
    assign w_is_mem     = (mode == MODE_MEM);
    assign w_is_br      = (mode == MODE_BR);
    assign w_is_cmp_tst = !w_is_mem && !w_is_br && (op_code == OP_CMP || op_code == OP_TST);

`ifdef MUL_EN
    assign w_mc_op   = id_valid && w_is_dp && (op_code == OP_EXP || op_code == OP_MUL);
    assign w_mul_sel = (op_code == OP_MUL);
`else
    assign w_mc_op   = id_valid && w_is_dp && (op_code == OP_EXP);
    assign w_mul_sel = 1'b0;
`endif

    // Reset also masks the start pulse so nothing launches while rst_n is low.
    assign w_start = rst_n && w_mc_op && !flush && !w_busy;

    cu_mc_timer #(
        .EXP_LAT (EXP_LAT),
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (w_start),
        .i_sel        (w_mul_sel),
        .i_flush      (flush),
        .o_busy       (w_busy),
        .o_done       (w_done),
        .o_stall_hold (w_stall_hold),
        .o_sel        (mc_sel)
    );

    assign mc_start = w_start;
    assign stall    = w_start || w_stall_hold;
    assign busy     = w_busy;

    always_comb begin
        mem_r_en = w_is_mem && s;
        mem_w_en = w_is_mem && !s;
        b        = w_is_br;
        exe_cmd  = w_is_br ? EXE_NOP : exe_cmd_of(op_code);
        s_out    = (w_is_mem || w_is_br) ? 1'b0 : (w_is_cmp_tst ? 1'b1 : s);
        wb_en    = 1'b1;
        if (w_is_br || (w_is_mem && !s) || w_is_cmp_tst)
            wb_en = 1'b0;
        // A multi-cycle result is written back only in an unflushed DONE cycle.
        if (w_mc_op && !(w_done && !flush))
            wb_en = 1'b0;
    end

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed self-checking bench for control_unit_mc (EXP_LAT=20, MUL_LAT=4, CNT_W=5).
// MUL checks adapt to whether MUL_EN is defined for the build.
module tb_control_unit_mc;
    import cu_pkg::*;

    localparam int EXP_LAT = 20;
    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 5;

    logic       clk = 1'b0;
    logic       rst_n, id_valid, flush, s;
    logic [1:0] mode;
    logic [3:0] op_code;
    logic       mem_r_en, mem_w_en, b, s_out, wb_en;
    logic [3:0] exe_cmd;
    logic       mc_start, mc_sel, stall, busy;

    int n_vec = 0;
    int n_err = 0;

    control_unit_mc #(.EXP_LAT(EXP_LAT), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .flush(flush), .s(s),
        .mode(mode), .op_code(op_code), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .b(b), .s_out(s_out), .wb_en(wb_en), .exe_cmd(exe_cmd), .mc_start(mc_start),
        .mc_sel(mc_sel), .stall(stall), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic fl, input logic sb,
                         input logic [1:0] md, input logic [3:0] op);
        id_valid = v; flush = fl; s = sb; mode = md; op_code = op;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, MODE_DP, OP_ADD);
    endtask

    task automatic check_dec(input string tag, input logic mr, input logic mw, input logic bb,
                             input logic so, input logic wb, input logic [3:0] cmd);
        check({tag, "_mem_r"}, mem_r_en, mr);
        check({tag, "_mem_w"}, mem_w_en, mw);
        check({tag, "_b"},     b,        bb);
        check({tag, "_s_out"}, s_out,    so);
        check({tag, "_wb"},    wb_en,    wb);
        check({tag, "_cmd"},   exe_cmd,  cmd);
    endtask

    // Issue a multi-cycle op in cycle 0 and follow it through DONE back to IDLE.
    task automatic run_op(input string tag, input logic [3:0] op, input int lat, input logic sel);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, MODE_DP, op);
        @(negedge clk);
        check({tag, "_c0_start"}, mc_start, 1'b1);
        check({tag, "_c0_stall"}, stall,    1'b1);
        check({tag, "_c0_busy"},  busy,     1'b0);
        check({tag, "_c0_wb"},    wb_en,    1'b0);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check($sformatf("%s_c%0d_start", tag, k), mc_start, 1'b0);
            check($sformatf("%s_c%0d_stall", tag, k), stall,    1'b1);
            check($sformatf("%s_c%0d_busy",  tag, k), busy,     1'b1);
            check($sformatf("%s_c%0d_wb",    tag, k), wb_en,    1'b0);
            if (k == 1) check({tag, "_sel"}, mc_sel, sel);
        end
        @(negedge clk);
        check({tag, "_done_wb"},    wb_en,    1'b1);
        check({tag, "_done_stall"}, stall,    1'b0);
        check({tag, "_done_busy"},  busy,     1'b1);
        check({tag, "_done_start"}, mc_start, 1'b0);
        next_cycle();
        bubble();
        @(negedge clk);
        check({tag, "_idle_busy"},  busy,  1'b0);
        check({tag, "_idle_stall"}, stall, 1'b0);
    endtask

    // Flush an EXP in cycle fc; the op must never reach DONE.
    task automatic flush_op(input string tag, input int fc);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, MODE_DP, OP_EXP);
        @(negedge clk);
        check({tag, "_c0_start"}, mc_start, 1'b1);
        for (int k = 1; k <= fc; k++) begin
            next_cycle();
            if (k == fc) flush = 1'b1;
            @(negedge clk);
            check($sformatf("%s_c%0d_busy", tag, k), busy, 1'b1);
        end
        check({tag, "_flush_wb"}, wb_en, 1'b0);
        next_cycle();
        bubble();
        for (int k = fc + 1; k <= EXP_LAT + 1; k++) begin
            @(negedge clk);
            check($sformatf("%s_c%0d_idle", tag, k), busy, 1'b0);
            check($sformatf("%s_c%0d_start", tag, k), mc_start, 1'b0);
        end
    endtask

    typedef struct { logic [3:0] op; logic [3:0] cmd; } dec_vec_t;

    initial begin
        dec_vec_t tbl[9];
        tbl[0] = '{OP_MOV, 4'b0001}; tbl[1] = '{OP_MVN, 4'b1001}; tbl[2] = '{OP_ADC, 4'b0011};
        tbl[3] = '{OP_SUB, 4'b0100}; tbl[4] = '{OP_SBC, 4'b0101}; tbl[5] = '{OP_AND, 4'b0110};
        tbl[6] = '{OP_ORR, 4'b0111}; tbl[7] = '{OP_EOR, 4'b1000}; tbl[8] = '{4'b1011, 4'b0000};

        rst_n = 1'b0;
        bubble();
        #1;
        check("rst_busy",  busy,     1'b0);
        check("rst_start", mc_start, 1'b0);
        check("rst_sel",   mc_sel,   1'b0);
        check("rst_stall", stall,    1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Decode sweep with the FSM idle.
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, MODE_DP, OP_ADD);
        @(negedge clk);
        check_dec("add", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, MODE_DP, OP_CMP);
        @(negedge clk);
        check_dec("cmp", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, MODE_DP, OP_TST);
        @(negedge clk);
        check_dec("tst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0110);
        foreach (tbl[i]) begin
            next_cycle();
            drive(1'b1, 1'b0, 1'b0, MODE_DP, tbl[i].op);
            @(negedge clk);
            check_dec($sformatf("dp_op%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tbl[i].cmd);
        end
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, MODE_MEM, OP_ADD);
        @(negedge clk);
        check_dec("ldr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, MODE_MEM, OP_ADD);
        @(negedge clk);
        check_dec("str", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010);
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, MODE_BR, OP_ADD);
        @(negedge clk);
        check_dec("br", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        check("br_stall", stall, 1'b0);

        // EXP in a bubble slot must not start.
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, MODE_DP, OP_EXP);
        @(negedge clk);
        check("exp_inval_start", mc_start, 1'b0);
        check("exp_inval_stall", stall,    1'b0);

        run_op("exp", OP_EXP, EXP_LAT, 1'b0);
        run_op("exp_b2b", OP_EXP, EXP_LAT, 1'b0);

`ifdef MUL_EN
        run_op("mul", OP_MUL, MUL_LAT, 1'b1);
`else
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, MODE_DP, OP_MUL);
        @(negedge clk);
        check("op7_stall", stall,    1'b0);
        check("op7_start", mc_start, 1'b0);
        check("op7_wb",    wb_en,    1'b1);
        check("op7_cmd",   exe_cmd,  4'b0000);
        next_cycle();
        bubble();
        @(negedge clk);
        check("op7_busy", busy, 1'b0);
`endif

        flush_op("flush10", 10);
        flush_op("flush_last", EXP_LAT - 1);

        // Asynchronous reset in cycle 7 of an EXP.
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, MODE_DP, OP_EXP);
        repeat (7) @(posedge clk);
        #2;
        check("mid_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  busy,     1'b0);
        check("mid_rst_start", mc_start, 1'b0);
        check("mid_rst_sel",   mc_sel,   1'b0);
        bubble();
        @(posedge clk);
        #1;
        check("mid_rst_hold", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("exp_after_rst", OP_EXP, EXP_LAT, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
